// File: rtl/stage_memory.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, data-memory handshake with timeout, load/store lane formatting.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module stage_memory #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_mem_in_data,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_write,
  input  logic        in_mem_read,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        out_stall,
  output logic [4:0]  out_EXMEM_rd,
  output logic        out_EXMEM_write_enable,
  output logic [31:0] out_EXMEM_alu_out,
  output logic [4:0]  out_MEMWB_rd,
  output logic        out_MEMWB_write_enable,
  output logic        out_MEMWB_mem_to_reg,
  output logic [31:0] out_MEMWB_out_data,
  output logic        out_bus_error,
  output logic        out_misaligned
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [31:0] exm_alu_q, exm_wdata_q;
  logic [4:0]  exm_rd_q;
  logic [2:0]  exm_f3_q;
  logic        exm_mw_q, exm_mr_q, exm_m2r_q, exm_we_q;

  logic [4:0]  wb_rd_q;
  logic        wb_we_q, wb_m2r_q;
  logic [31:0] wb_data_q;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        mem_op, misalign, timeout, complete, error;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign mem_op = exm_mr_q | exm_mw_q;
  assign lane   = exm_alu_q[1:0];

`ifdef MISALIGN_TRAP_EN
  assign misalign = mem_op &&
                    ((exm_f3_q[1:0] == 2'b01 && lane[0]) ||
                     (exm_f3_q == 3'b010 && lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign timeout   = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES));
  assign dmem_req  = mem_op && !misalign && !timeout;
  assign complete  = dmem_req && dmem_ready;
  assign error     = timeout | misalign;
  assign out_stall = mem_op && !complete && !error;

  assign out_bus_error  = timeout;
  assign out_misaligned = misalign;

  assign dmem_we   = exm_mw_q;
  assign dmem_addr = {exm_alu_q[31:2], 2'b00};

  // Store lane steering: data is replicated so any enabled lane carries it.
  always_comb begin
    dmem_wdata = exm_wdata_q;
    dmem_be    = 4'b1111;
    case (exm_f3_q[1:0])
      2'b00: begin
        dmem_wdata = {4{exm_wdata_q[7:0]}};
        dmem_be    = 4'b0001 << lane;
      end
      2'b01: begin
        dmem_wdata = {2{exm_wdata_q[15:0]}};
        dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!exm_mw_q) dmem_be = 4'b0000;
  end

  always_comb begin
    ld_byte = dmem_rdata[8*lane +: 8];
    ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (exm_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (dmem_req && !dmem_ready) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (timeout || dmem_ready) state_d = IDLE;
            else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      exm_alu_q   <= '0;
      exm_wdata_q <= '0;
      exm_rd_q    <= '0;
      exm_f3_q    <= '0;
      exm_mw_q    <= 1'b0;
      exm_mr_q    <= 1'b0;
      exm_m2r_q   <= 1'b0;
      exm_we_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_m2r_q    <= 1'b0;
      wb_data_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!out_stall) begin
        exm_alu_q   <= in_alu_out;
        exm_wdata_q <= in_mem_in_data;
        exm_rd_q    <= in_rd;
        exm_f3_q    <= in_funct3;
        exm_mw_q    <= in_mem_write;
        exm_mr_q    <= in_mem_read;
        exm_m2r_q   <= in_mem_to_reg;
        exm_we_q    <= in_write_enable;
      end
      // A stalled or faulted op leaves a bubble behind it in MEM/WB.
      if (out_stall || error) begin
        wb_rd_q   <= '0;
        wb_we_q   <= 1'b0;
        wb_m2r_q  <= 1'b0;
        wb_data_q <= '0;
      end else begin
        wb_rd_q   <= exm_rd_q;
        wb_we_q   <= exm_we_q;
        wb_m2r_q  <= exm_m2r_q;
        wb_data_q <= exm_mr_q ? ld_data : exm_alu_q;
      end
    end
  end

  assign out_EXMEM_rd           = exm_rd_q;
  assign out_EXMEM_write_enable = exm_we_q;
  assign out_EXMEM_alu_out      = exm_alu_q;
  assign out_MEMWB_rd           = wb_rd_q;
  assign out_MEMWB_write_enable = wb_we_q;
  assign out_MEMWB_mem_to_reg   = wb_m2r_q;
  assign out_MEMWB_out_data     = wb_data_q;

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum number of WAIT cycles before a bus error is declared.
REQ-002 clk  in  1  rising-edge clock, the single clock of the block.
REQ-003 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_alu_out  in  32  effective address or ALU result from execute.
REQ-005 in_mem_in_data  in  32  store data (rs2) from execute.
REQ-006 in_rd  in  5  destination register.
REQ-007 in_funct3  in  3  access size and signedness.
REQ-008 in_mem_write, in_mem_read, in_mem_to_reg, in_write_enable  in  1 each  control bits from execute; all zero indicates a bubble.
REQ-009 dmem_req, dmem_we  out  1 each  request strobe and write select.
REQ-010 dmem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-011 dmem_wdata  out  32  lane-shifted store data.
REQ-012 dmem_be  out  4  byte enables.
REQ-013 dmem_ready  in  1  request accepted or completed this cycle.
REQ-014 dmem_rdata  in  32  read word, valid when dmem_ready is high.
REQ-015 out_stall  out  1  freeze upstream stages; combinational.
REQ-016 out_EXMEM_rd, out_EXMEM_write_enable, out_EXMEM_alu_out  out  5/1/32  EX/MEM register contents, used for forwarding.
REQ-017 out_MEMWB_rd, out_MEMWB_write_enable, out_MEMWB_mem_to_reg, out_MEMWB_out_data  out  5/1/1/32  MEM/WB register contents.
REQ-018 out_bus_error, out_misaligned  out  1 each  single-cycle error pulses.

Function
REQ-019 EX/MEM register: captures all in_* signals on a rising edge when out_stall is 0; holds its value while out_stall is 1.
REQ-020 mem_op = EXMEM mem_read OR EXMEM mem_write.
REQ-021 FSM states are IDLE and WAIT.
REQ-022 IDLE behaviour:
- dmem_req = mem_op.
- If dmem_ready=1 in the same cycle, the access completes (zero-wait).
- Otherwise the FSM moves to WAIT.
REQ-023 WAIT behaviour:
- dmem_req and all address/data/enable outputs are held stable.
- On dmem_ready=1, the access completes and the FSM returns to IDLE.
REQ-024 out_stall = mem_op AND NOT completion AND NOT error, evaluated combinationally.
REQ-025 Timeout:
- A wait counter is cleared on entry to WAIT.
- When the counter reaches TIMEOUT_CYCLES, dmem_req drops, out_bus_error pulses for one cycle, the stall releases, the MEM/WB stage receives a bubble, and the FSM returns to IDLE.
REQ-026 MEM/WB register, on every rising edge:
- On completion or for a non-memory op, it captures the EX/MEM value.
- While stalled or on an error, it captures a bubble (write_enable=0, rd=0).
REQ-027 out_MEMWB_out_data:
- Equals the formatted load data when mem_read is set.
- Otherwise equals the EXMEM alu_out.
REQ-028 Load formatting by funct3, using byte lane addr[1:0]:
- 000 LB: sign-extended byte.
- 001 LH: sign-extended half selected by addr[1].
- 010 LW: full word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended half.
- Other funct3 values: treated as LW.
REQ-029 Stores:
- SB: be = 0001 shifted left by addr[1:0]; the byte is replicated to all lanes.
- SH: be = 0011 or 1100 selected by addr[1]; the half is replicated.
- SW: be = 1111.
- dmem_be = 0000 when the operation is a load.
REQ-030 A store completes with MEM/WB write_enable taken from EXMEM; a store with write_enable=1 is passed through unchanged.
REQ-031 Bubbles (all control bits zero) never assert dmem_req and never stall.

Reset
REQ-032 Synchronous reset (reset=0 at a rising edge):
- EX/MEM and MEM/WB registers go to all zero.
- FSM goes to IDLE and the wait counter to 0.
- All outputs read 0 in the following cycle, including dmem_req and out_stall.
REQ-033 Reset asserted during WAIT abandons the access without an error pulse.

Configuration
REQ-034 Macro MISALIGN_TRAP_EN, defined:
- The block checks LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]≠0.
- Such an access issues no request and does not stall, pulses out_misaligned for one cycle, and sends a bubble to MEM/WB.
REQ-035 Macro MISALIGN_TRAP_EN, undefined:
- The misalignment check is not compiled in and out_misaligned is tied to 0.
- Halfword accesses use addr[1] only; word accesses ignore addr[1:0].

Verification
REQ-036 SW with alu_out=0x100, data=0xDEADBEEF, dmem_ready=1 -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, no stall.
REQ-037 LB at 0x103 with rdata=0x80000000 -> MEM/WB out_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 LW with dmem_ready low for 3 cycles -> out_stall high for exactly 3 cycles, EX/MEM held, 3 MEM/WB bubbles, then data captured.
REQ-039 dmem_ready never asserted -> out_bus_error pulses after TIMEOUT_CYCLES WAIT cycles, stall releases, rd not written.
REQ-040 SH at 0x102 with data 0x0000ABCD -> be=1100, wdata=0xABCDABCD; with MISALIGN_TRAP_EN, LW at 0x101 -> out_misaligned=1, dmem_req=0.
